// File: rtl/riscv_ctrl_pkg.sv
// Encodings shared by the multicycle controller, the sign extender
// and the single-cycle decoder; ILLEGAL_TRAP_EN adds the TRAP state.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_LUI,
        S_JAL,
        S_ALUWB,
        S_BRANCH
`ifdef ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_U = 3'b001,
        IMM_S = 3'b010,
        IMM_B = 3'b011,
        IMM_J = 3'b100
    } imm_src_t;

    typedef enum logic [2:0] {
        CL_LOAD,
        CL_STORE,
        CL_RTYPE,
        CL_ITYPE,
        CL_BRANCH,
        CL_JAL,
        CL_LUI,
        CL_ILLEGAL
    } instr_class_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RD1   = 2'b10,
        SRCA_ZERO  = 2'b11
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRCB_RD2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> datapath/memory bundle; master is the controller side.
interface multicycle_control_fsm_if;

    logic [6:0] Op;
    logic       Funct3b0;
    logic       Zero;
    logic       MemReady;
    logic       MemReq;
    logic       MemWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [2:0] ImmSrc;
    logic       MemTimeout;
    logic       IllegalInstr;

    modport master (
        input  Op, Funct3b0, Zero, MemReady,
        output MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
        output MemTimeout, IllegalInstr
    );

    modport slave (
        output Op, Funct3b0, Zero, MemReady,
        input  MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
        input  MemTimeout, IllegalInstr
    );

endinterface

// File: rtl/imm_src_decode.sv
// Combinational opcode decode: immediate format and instruction class.
module imm_src_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0]   op,
    output imm_src_t     imm_src,
    output instr_class_t iclass
);

    always_comb begin
        imm_src = IMM_I;
        iclass  = CL_ILLEGAL;
        unique case (1'b1)
            (op == OP_LW): begin
                imm_src = IMM_I;
                iclass  = CL_LOAD;
            end
            (op == OP_SW): begin
                imm_src = IMM_S;
                iclass  = CL_STORE;
            end
            (op == OP_RTYPE): begin
                imm_src = IMM_I;
                iclass  = CL_RTYPE;
            end
            (op == OP_ITYPE): begin
                imm_src = IMM_I;
                iclass  = CL_ITYPE;
            end
            (op == OP_BRANCH): begin
                imm_src = IMM_B;
                iclass  = CL_BRANCH;
            end
            (op == OP_JAL): begin
                imm_src = IMM_J;
                iclass  = CL_JAL;
            end
            (op == OP_LUI): begin
                imm_src = IMM_U;
                iclass  = CL_LUI;
            end
            default: begin
                imm_src = IMM_I;
                iclass  = CL_ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I main controller with memory wait-state handshake.
// Define ILLEGAL_TRAP_EN to trap on illegal opcodes instead of NOP.
module multicycle_control_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    multicycle_control_fsm_if.master bus
);

    localparam int CW =
        (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0] WAIT_LIM = CW'(MEM_WAIT_MAX);

    state_t       state;
    imm_src_t     imm_op;
    instr_class_t iclass;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] cnt_inc;
    logic          timeout;
    logic          stall;

    logic        mem_req;
    logic        mem_write;
    logic        adr_src;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    result_src_t result_src;
    alu_src_a_t  alu_src_a;
    alu_src_b_t  alu_src_b;
    alu_op_t     alu_op;

`ifdef ILLEGAL_TRAP_EN
    logic illegal;
`endif

    imm_src_decode u_dec (
        .op      (bus.Op),
        .imm_src (imm_op),
        .iclass  (iclass)
    );

    // Stall never coincides with a state change, so a non-stall cycle
    // is exactly when the wait counter must clear.
    assign stall   = mem_req & ~bus.MemReady;
    assign cnt_inc = (wait_cnt == WAIT_LIM) ? wait_cnt
                                            : wait_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            timeout  <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal  <= 1'b0;
`endif
        end else begin
            if (stall) begin
                wait_cnt <= cnt_inc;
                if (MEM_WAIT_MAX > 0 && cnt_inc == WAIT_LIM)
                    timeout <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            unique case (state)
                S_FETCH:
                    if (bus.MemReady) state <= S_DECODE;
                S_DECODE:
                    unique case (iclass)
                        CL_LOAD:   state <= S_MEMADR;
                        CL_STORE:  state <= S_MEMADR;
                        CL_RTYPE:  state <= S_EXECR;
                        CL_ITYPE:  state <= S_EXECI;
                        CL_BRANCH: state <= S_BRANCH;
                        CL_JAL:    state <= S_JAL;
                        CL_LUI:    state <= S_LUI;
                        CL_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
                            state   <= S_TRAP;
                            illegal <= 1'b1;
`else
                            state   <= S_FETCH;
`endif
                        end
                    endcase
                S_MEMADR:
                    state <= (iclass == CL_STORE) ? S_MEMWRITE
                                                  : S_MEMREAD;
                S_MEMREAD:
                    if (bus.MemReady) state <= S_MEMWB;
                S_MEMWRITE:
                    if (bus.MemReady) state <= S_FETCH;
                S_EXECR,
                S_EXECI,
                S_LUI,
                S_JAL:
                    state <= S_ALUWB;
                S_MEMWB,
                S_ALUWB,
                S_BRANCH:
                    state <= S_FETCH;
`ifdef ILLEGAL_TRAP_EN
                S_TRAP:
                    state <= S_TRAP;
`endif
                default:
                    state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALU_ADD;
        unique case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = bus.MemReady;
                pc_write   = bus.MemReady;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALU_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_FUNCT;
            end
            S_LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALU_SUB;
                pc_write  = bus.Zero ^ bus.Funct3b0;
            end
            default: ;
        endcase
    end

    assign bus.MemReq    = mem_req   & ~reset;
    assign bus.MemWrite  = mem_write & ~reset;
    assign bus.IRWrite   = ir_write  & ~reset;
    assign bus.PCWrite   = pc_write  & ~reset;
    assign bus.RegWrite  = reg_write & ~reset;
    assign bus.AdrSrc    = adr_src;
    assign bus.ResultSrc = result_src;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ALUOp     = alu_op;
    assign bus.ImmSrc    = (state == S_FETCH) ? IMM_I : imm_op;
    assign bus.MemTimeout = timeout;
`ifdef ILLEGAL_TRAP_EN
    assign bus.IllegalInstr = illegal;
`else
    assign bus.IllegalInstr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: instruction-level
// sequencer pushes per-cycle expectations, a monitor compares them.
module tb_multicycle_control_fsm;

    localparam int MAXW = 4;

    typedef enum int {
        T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB,
        T_MEMWRITE, T_EXECR, T_EXECI, T_LUI, T_JAL,
        T_ALUWB, T_BRANCH, T_TRAP, T_RESET
    } step_t;

    typedef struct packed {
        logic req, mw, adr, irw, pcw, rw;
        logic [1:0] res, a, b, aop;
        logic [2:0] imm;
        logic tmo, ill;
    } out_t;

    typedef struct {
        step_t step;
        out_t  exp;
        out_t  mask;
    } entry_t;

    entry_t sb[$];
    int compared   = 0;
    int mismatched = 0;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    bit   m_tmo;
    bit   m_ill;
    int   stall_run;

    logic [6:0] legal_ops [7] = '{
        7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
        7'b1100011, 7'b1101111, 7'b0110111
    };

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm #(.MEM_WAIT_MAX(MAXW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] imm_of(logic [6:0] op);
        case (op)
            7'b0110111: return 3'b001;
            7'b0100011: return 3'b010;
            7'b1100011: return 3'b011;
            7'b1101111: return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

    function automatic out_t expect_out(step_t s, logic [6:0] op,
                                        logic f3, logic z, logic rdy);
        out_t o = '0;
        o.imm = (s == T_FETCH) ? 3'b000 : imm_of(op);
        case (s)
            T_FETCH: begin
                o.req = 1; o.b = 2; o.res = 2;
                o.irw = rdy; o.pcw = rdy;
            end
            T_DECODE:   begin o.a = 1; o.b = 1; end
            T_MEMADR:   begin o.a = 2; o.b = 1; end
            T_MEMREAD:  begin o.req = 1; o.adr = 1; end
            T_MEMWB:    begin o.res = 1; o.rw = 1; end
            T_MEMWRITE: begin o.req = 1; o.mw = 1; o.adr = 1; end
            T_EXECR:    begin o.a = 2; o.aop = 2; end
            T_EXECI:    begin o.a = 2; o.b = 1; o.aop = 2; end
            T_LUI:      begin o.a = 3; o.b = 1; end
            T_JAL:      begin o.a = 1; o.b = 2; o.pcw = 1; end
            T_ALUWB:    o.rw = 1;
            T_BRANCH:   begin o.a = 2; o.aop = 1; o.pcw = z ^ f3; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic cyc(step_t s, logic rst, logic rdy,
                       logic [6:0] op, logic f3, logic z);
        entry_t e;
        @(posedge clk);
        #1;
        reset        = rst;
        bus.MemReady = rdy;
        bus.Op       = op;
        bus.Funct3b0 = f3;
        bus.Zero     = z;
        e.step = s;
        if (rst) begin
            e.exp  = '0;
            e.mask = '0;
            e.mask.req = 1; e.mask.mw = 1; e.mask.irw = 1;
            e.mask.pcw = 1; e.mask.rw = 1;
        end else begin
            e.exp     = expect_out(s, op, f3, z, rdy);
            e.exp.tmo = m_tmo;
            e.exp.ill = m_ill;
            e.mask    = '1;
        end
        sb.push_back(e);
        if (rst) begin
            m_tmo = 0; m_ill = 0; stall_run = 0;
        end else if (s == T_FETCH || s == T_MEMREAD || s == T_MEMWRITE) begin
            if (!rdy) begin
                stall_run++;
                if (MAXW > 0 && stall_run >= MAXW) m_tmo = 1;
            end else begin
                stall_run = 0;
            end
        end else if (s == T_DECODE) begin
`ifdef ILLEGAL_TRAP_EN
            if (!(op inside {legal_ops})) m_ill = 1;
`endif
        end
    endtask

    task automatic one(step_t s, logic [6:0] op, logic f3, logic z);
        cyc(s, 1'b0, 1'($urandom), op, f3, z);
    endtask

    task automatic access(step_t s, logic [6:0] op, logic f3, int waits);
        for (int i = 0; i < waits; i++)
            cyc(s, 1'b0, 1'b0, op, f3, 1'($urandom));
        cyc(s, 1'b0, 1'b1, op, f3, 1'($urandom));
    endtask

    task automatic do_reset(int n);
        for (int i = 0; i < n; i++)
            cyc(T_RESET, 1'b1, 1'($urandom), 7'($urandom), 1'b0, 1'b0);
    endtask

    task automatic do_instr(logic [6:0] op, logic f3, logic z,
                            int wf, int wm);
        access(T_FETCH, 7'($urandom), 1'($urandom), wf);
        one(T_DECODE, op, f3, 1'($urandom));
        case (op)
            7'b0000011: begin
                one(T_MEMADR, op, f3, 1'($urandom));
                access(T_MEMREAD, op, f3, wm);
                one(T_MEMWB, op, f3, 1'($urandom));
            end
            7'b0100011: begin
                one(T_MEMADR, op, f3, 1'($urandom));
                access(T_MEMWRITE, op, f3, wm);
            end
            7'b0110011: begin
                one(T_EXECR, op, f3, 1'($urandom));
                one(T_ALUWB, op, f3, 1'($urandom));
            end
            7'b0010011: begin
                one(T_EXECI, op, f3, 1'($urandom));
                one(T_ALUWB, op, f3, 1'($urandom));
            end
            7'b0110111: begin
                one(T_LUI, op, f3, 1'($urandom));
                one(T_ALUWB, op, f3, 1'($urandom));
            end
            7'b1101111: begin
                one(T_JAL, op, f3, 1'($urandom));
                one(T_ALUWB, op, f3, 1'($urandom));
            end
            7'b1100011: one(T_BRANCH, op, f3, z);
            default: begin
`ifdef ILLEGAL_TRAP_EN
                for (int i = 0; i < 3; i++)
                    one(T_TRAP, op, f3, 1'($urandom));
                do_reset(1);
`endif
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            entry_t e;
            out_t got;
            e   = sb.pop_front();
            got = {bus.MemReq, bus.MemWrite, bus.AdrSrc, bus.IRWrite,
                   bus.PCWrite, bus.RegWrite, bus.ResultSrc,
                   bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc,
                   bus.MemTimeout, bus.IllegalInstr};
            compared++;
            if ((got & e.mask) !== (e.exp & e.mask)) begin
                mismatched++;
                $display("FAIL %s t=%0t got=%h want=%h mask=%h",
                         e.step.name(), $time, got & e.mask,
                         e.exp & e.mask, e.mask);
            end
        end
    end

    initial begin
        int w;
        logic [6:0] op;
        bus.Op = '0; bus.Funct3b0 = 0; bus.Zero = 0; bus.MemReady = 0;
        m_tmo = 0; m_ill = 0; stall_run = 0;

        do_reset(2);
        do_instr(7'b0110011, 0, 0, 0, 0);
        do_instr(7'b0000011, 0, 0, 0, 3);
        do_instr(7'b1100011, 0, 1, 1, 0);
        do_instr(7'b1100011, 1, 1, 0, 0);
        do_instr(7'b1100011, 0, 0, 0, 0);
        do_instr(7'b1100011, 1, 0, 2, 0);
        do_instr(7'b0100011, 0, 0, 0, 6);
        do_instr(7'b0010011, 0, 0, 1, 0);

        cyc(T_FETCH,    0, 1, 7'h00, 0, 0);
        cyc(T_DECODE,   0, 0, 7'b0100011, 0, 0);
        cyc(T_MEMADR,   0, 1, 7'b0100011, 0, 0);
        for (int i = 0; i < 5; i++)
            cyc(T_MEMWRITE, 0, 0, 7'b0100011, 0, 0);
        cyc(T_RESET,    1, 0, 7'b0100011, 0, 0);
        do_instr(7'b1101111, 0, 0, 0, 0);

        do_instr(7'b1111111, 0, 0, 0, 0);
        do_instr(7'b0110111, 0, 0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            int k = $urandom_range(0, 7);
            if (k == 7) op = 7'($urandom);
            else        op = legal_ops[k];
            do_instr(op, 1'($urandom), 1'($urandom),
                     $urandom_range(0, 5), $urandom_range(0, 6));
            if ($urandom_range(0, 14) == 0) do_reset(1);
        end

        w = 0;
        while (sb.size() > 0 && w < 10) begin
            @(posedge clk);
            w++;
        end
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
